// File: rtl/snd_cmd_queue_pkg.sv
// Shared board definitions for the sound-command latch queue.
// Holds the RST vector constants and the interrupt-vector helper.
package snd_cmd_queue_pkg;

  localparam int unsigned SND_DATA_W = 8;
  localparam int unsigned SND_LVL_W  = 4;

  localparam logic [SND_DATA_W-1:0] SND_VEC_IDLE       = 8'hFF;
  localparam logic [SND_DATA_W-1:0] SND_VEC_LATCH_MASK = 8'hDF;
  localparam logic [SND_DATA_W-1:0] SND_VEC_YM_MASK    = 8'hEF;

  // Each pending source clears one bit of the idle RST 38h opcode.
  function automatic logic [SND_DATA_W-1:0] snd_int_vec(input logic latch_irq,
                                                        input logic ym_irq);
    logic [SND_DATA_W-1:0] v;
    v = SND_VEC_IDLE;
    if (latch_irq) v = v & SND_VEC_LATCH_MASK;
    if (ym_irq)    v = v & SND_VEC_YM_MASK;
    return v;
  endfunction

endpackage

// File: rtl/snd_cmd_queue.sv
// Main-CPU to sound-CPU command FIFO with level-to-edge write/ack
// detection and a combined latch/FM interrupt request and vector.
module snd_cmd_queue
  import snd_cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [SND_DATA_W-1:0] din,
  input  logic                  ack,
  input  logic                  ym_irq,
  output logic [SND_DATA_W-1:0] dout,
  output logic                  int_n,
  output logic [SND_DATA_W-1:0] int_vector,
  output logic                  latch_rdy,
  output logic                  full,
  output logic                  overflow,
  output logic [SND_LVL_W-1:0]  level
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic                  r_wr_q;
  logic                  r_ack_q;
  logic                  r_arm;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [SND_LVL_W-1:0]  r_count;
  logic                  r_overflow;
  logic [SND_DATA_W-1:0] r_dout;
  logic                  r_int_n;
  logic [SND_DATA_W-1:0] r_int_vector;
  logic [SND_DATA_W-1:0] r_mem [DEPTH];

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_do_push;
  logic                  w_do_pop;
  logic                  w_drop;
  logic                  w_latch_irq;
  logic [PTR_W-1:0]      w_head_nxt;
  logic [PTR_W-1:0]      w_tail_nxt;

  // r_arm blocks the first post-reset sample so a level held through reset is not an edge.
  assign w_push      = r_arm & wr  & ~r_wr_q;
  assign w_pop       = r_arm & ack & ~r_ack_q;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == SND_LVL_W'(DEPTH));
  assign w_do_pop    = w_pop & ~w_empty;
  assign w_do_push   = w_push & (~w_full | w_do_pop);
  assign w_drop      = w_push & w_full & ~w_do_pop;
  assign w_latch_irq = ~w_empty;

  assign w_head_nxt  = (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
  assign w_tail_nxt  = (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + PTR_W'(1);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_q  <= 1'b0;
      r_ack_q <= 1'b0;
      r_arm   <= 1'b0;
    end else begin
      r_wr_q  <= wr;
      r_ack_q <= ack;
      r_arm   <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_pop)  r_head <= w_head_nxt;
      if (w_do_push) r_tail <= w_tail_nxt;
      if (w_do_push && !w_do_pop)      r_count <= r_count + SND_LVL_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - SND_LVL_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_tail] <= din;
  end

  // Head byte and interrupt outputs trail the pointer/count state by one clock.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dout       <= SND_VEC_IDLE;
      r_int_n      <= 1'b1;
      r_int_vector <= SND_VEC_IDLE;
    end else begin
      r_dout       <= w_empty ? 8'hFF : r_mem[r_head];
      r_int_n      <= ~(w_latch_irq | ym_irq);
      r_int_vector <= snd_int_vec(w_latch_irq, ym_irq);
    end
  end

  assign dout       = r_dout;
  assign int_n      = r_int_n;
  assign int_vector = r_int_vector;
  assign overflow   = r_overflow;
  assign latch_rdy  = ~w_empty;
  assign full       = w_full;
  assign level      = r_count;

endmodule

// File: tb/tb_snd_cmd_queue.sv
// Directed bench for snd_cmd_queue with a byte-queue scoreboard.
module tb_snd_cmd_queue;

  localparam int unsigned DEPTH = 4;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       wr;
  logic [7:0] din;
  logic       ack;
  logic       ym_irq;
  logic [7:0] dout;
  logic       int_n;
  logic [7:0] int_vector;
  logic       latch_rdy;
  logic       full;
  logic       overflow;
  logic [3:0] level;

  logic [7:0] sb_q[$];
  logic       m_ovf;
  logic       m_ym;
  int         n_cmp;
  int         n_err;

  snd_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .wr         (wr),
    .din        (din),
    .ack        (ack),
    .ym_irq     (ym_irq),
    .dout       (dout),
    .int_n      (int_n),
    .int_vector (int_vector),
    .latch_rdy  (latch_rdy),
    .full       (full),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    logic [7:0] exp_vec;
    logic       lat;
    lat = (sb_q.size() != 0);
    exp_vec = (lat && m_ym) ? 8'hCF : lat ? 8'hDF : m_ym ? 8'hEF : 8'hFF;
    check({tag, ".level"},    8'(level),     8'(sb_q.size()));
    check({tag, ".full"},     8'(full),      8'(sb_q.size() == DEPTH));
    check({tag, ".rdy"},      8'(latch_rdy), 8'(lat));
    check({tag, ".ovf"},      8'(overflow),  8'(m_ovf));
    check({tag, ".dout"},     dout,          lat ? sb_q[0] : 8'hFF);
    check({tag, ".int_n"},    8'(int_n),     8'(!(lat || m_ym)));
    check({tag, ".vec"},      int_vector,    exp_vec);
  endtask

  task automatic do_push(input logic [7:0] b, input int hold);
    din = b;
    wr  = 1'b1;
    tick(hold);
    wr  = 1'b0;
    tick(1);
    if (sb_q.size() < DEPTH) sb_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic do_pop(input string tag);
    logic [7:0] exp;
    exp = 8'hFF;
    if (sb_q.size() != 0) exp = sb_q.pop_front();
    check({tag, ".pop"}, dout, exp);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(1);
  endtask

  task automatic do_both(input string tag, input logic [7:0] b);
    logic [7:0] exp;
    exp = 8'hFF;
    if (sb_q.size() != 0) exp = sb_q.pop_front();
    check({tag, ".pop"}, dout, exp);
    din = b;
    wr  = 1'b1;
    ack = 1'b1;
    tick(1);
    wr  = 1'b0;
    ack = 1'b0;
    tick(1);
    sb_q.push_back(b);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    m_ovf   = 1'b0;
    m_ym    = 1'b0;
    reset_n = 1'b0;
    wr      = 1'b0;
    ack     = 1'b0;
    din     = 8'h00;
    ym_irq  = 1'b0;
    tick(3);
    check_status("reset");
    reset_n = 1'b1;
    tick(2);

    // Long write strobe yields a single entry
    do_push(8'h12, 5);
    check_status("hold5");
    do_pop("hold5");
    check_status("hold5_empty");

    // Pop on empty is ignored
    do_pop("empty_pop");
    check_status("empty_pop");

    // Simultaneous push/pop while full: no overflow
    for (int i = 0; i < 4; i++) do_push(8'hA0 + 8'(i), 1);
    check_status("full4");
    do_both("full_both", 8'h77);
    check_status("full_both");
    for (int i = 0; i < 4; i++) do_pop("full_drain");
    check_status("full_drained");

    // Simultaneous push/pop on empty: only the push lands
    do_both("empty_both", 8'h5A);
    check_status("empty_both");
    do_pop("empty_both");

    // Overflow: fifth push dropped, order preserved
    for (int i = 1; i <= 4; i++) do_push(8'(i), 1);
    check_status("ovf_full");
    do_push(8'h05, 1);
    check_status("ovf_drop");
    for (int i = 0; i < 4; i++) do_pop("ovf_drain");
    check_status("ovf_empty");

    // FM interrupt combined with latch interrupt
    ym_irq = 1'b1;
    m_ym   = 1'b1;
    tick(2);
    check_status("ym_only");
    do_push(8'h40, 1);
    check_status("ym_latch");
    do_pop("ym_latch");
    check_status("ym_after_ack");
    ym_irq = 1'b0;
    m_ym   = 1'b0;
    tick(2);
    check_status("ym_clear");

    // Simultaneous push/pop at level 2
    do_push(8'h21, 1);
    do_push(8'h22, 1);
    do_both("mid_both", 8'h23);
    check_status("mid_both");
    do_pop("mid_drain");
    do_pop("mid_drain");
    check_status("mid_empty");

    // Pointer wrap with push/pop pairs
    do_push(8'hB0, 1);
    for (int i = 1; i <= 10; i++) begin
      do_push(8'hB0 + 8'(i), 1);
      do_pop("wrap");
    end
    check_status("wrap_end");
    do_pop("wrap_last");

    // Reset mid-operation with wr held high
    do_push(8'h31, 1);
    do_push(8'h32, 1);
    din = 8'h33;
    wr  = 1'b1;
    tick(2);
    sb_q.push_back(8'h33);
    check_status("pre_rst");
    reset_n = 1'b0;
    tick(2);
    sb_q.delete();
    m_ovf = 1'b0;
    check_status("in_rst");
    reset_n = 1'b1;
    tick(3);
    check_status("rst_release_wr_high");
    wr = 1'b0;
    tick(1);
    check_status("wr_fall");
    do_push(8'h66, 1);
    check_status("post_rst_push");
    do_pop("post_rst");
    check_status("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
